pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID-stage hazard inputs and control outputs for pipe_hazard_ctrl.
// The master drives the ID/branch/memory status; the slave is the hazard unit.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 3
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              branch_taken;
  logic              mem_ready;

  logic              freeze;
  logic              hazard;
  logic              flush;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
           id_mem_read, branch_taken, mem_ready,
    input  freeze, hazard, flush, fwd_sel_a, fwd_sel_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
           id_mem_read, branch_taken, mem_ready,
    output freeze, hazard, flush, fwd_sel_a, fwd_sel_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks destination records of the post-ID
// stages, detects RAW hazards (load-use in forwarding mode, any in-flight
// producer in stall-only mode), drives freeze/bubble/flush, selects the
// forwarding source for the instruction entering EXE and counts stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned BR_FLUSH = 1
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  // The WB stage record can never influence any output (the register file is
  // write-first and WB results are never forwarded), so only stages
  // 1..DEPTH-1 are stored; likewise mem_read only matters in stage 1.
  logic [DEPTH-1:1] r_vld;
  logic [DEPTH-1:1] r_wb;
  logic [REG_AW-1:0] r_dest [1:DEPTH-1];
  logic              r_mrd1;

  logic [1:0]        r_fl_cnt;
  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic [15:0]       r_stall;

  logic [DEPTH-1:1]  w_m1;
  logic [DEPTH-1:1]  w_m2;
  logic              w_flush;
  logic              w_raw;
  logic              w_hazard;
  logic              w_issue;
  logic [SEL_W-1:0]  w_sel_a_nxt;
  logic [SEL_W-1:0]  w_sel_b_nxt;

  // Source-vs-stage destination matches.
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    for (int unsigned k = 1; k <= DEPTH - 1; k++) begin
      w_m1[k] = bus.id_valid && r_vld[k] && r_wb[k] && (r_dest[k] == bus.id_src1);
      w_m2[k] = bus.id_valid && bus.id_two_src && r_vld[k] && r_wb[k] &&
                (r_dest[k] == bus.id_src2);
    end
  end

  // Hazard, flush and issue decisions (zero latency, suppressed during reset).
  always_comb begin
    w_flush = rst && (bus.branch_taken || (r_fl_cnt != '0));
    if (FWD_EN != 0) begin
      w_raw = (w_m1[1] || w_m2[1]) && r_mrd1;
    end else begin
      w_raw = |(w_m1 | w_m2);
    end
    w_hazard = w_raw && !w_flush;
    w_issue  = bus.id_valid && !w_hazard && !w_flush;
  end

  // Forwarding source: youngest matching stage wins, shifted by one because
  // the producer advances on the same edge the consumer enters EXE.
  always_comb begin
    w_sel_a_nxt = '0;
    w_sel_b_nxt = '0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (w_m1[k]) w_sel_a_nxt = SEL_W'(k + 1);
      if (w_m2[k]) w_sel_b_nxt = SEL_W'(k + 1);
    end
  end

  // Stage records advance on mem_ready; stage 1 takes ID or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= '0;
      r_wb   <= '0;
      r_mrd1 <= 1'b0;
      for (int unsigned k = 1; k <= DEPTH - 1; k++) r_dest[k] <= '0;
    end else if (bus.mem_ready) begin
      r_vld[1]  <= w_issue;
      r_wb[1]   <= bus.id_wb_en;
      r_mrd1    <= bus.id_mem_read;
      r_dest[1] <= bus.id_dest;
      for (int unsigned k = 2; k <= DEPTH - 1; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_wb[k]   <= r_wb[k-1];
        r_dest[k] <= r_dest[k-1];
      end
    end
  end

  // Remaining flush cycles after the branch cycle; a new branch restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fl_cnt <= '0;
    end else if (bus.mem_ready) begin
      if (bus.branch_taken) begin
        r_fl_cnt <= 2'(BR_FLUSH - 1);
      end else if (r_fl_cnt != '0) begin
        r_fl_cnt <= r_fl_cnt - 2'd1;
      end
    end
  end

  // Forwarding selects for the instruction now in EXE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (bus.mem_ready) begin
      if ((FWD_EN != 0) && w_issue) begin
        r_sel_a <= w_sel_a_nxt;
        r_sel_b <= w_sel_b_nxt;
      end else begin
        r_sel_a <= '0;
        r_sel_b <= '0;
      end
    end
  end

  // Saturating count of hazard cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_hazard && (r_stall != '1)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.hazard    = w_hazard;
  assign bus.flush     = w_flush;
  assign bus.freeze    = w_hazard || !bus.mem_ready;
  assign bus.fwd_sel_a = r_sel_a;
  assign bus.fwd_sel_b = r_sel_b;
  assign bus.stall_cnt = r_stall;
endmodule
